dcache_wb_buffer: RTL and testbench

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

---
 rtl/L1_cache_types.sv | 19 +
 rtl/lc3b_types.sv | 6 +
 rtl/wb_fifo.sv | 78 +++++++
 rtl/dcache_wb_buffer.sv | 139 +++++++++++++
 tb/tb_dcache_wb_buffer.sv | 614 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/L1_cache_types.sv
// Shared L1 cache types: memory bus word, line tag and write-back buffer FSM states.
// Build option DCACHE_WB_FWD_EN adds the forwarding state to the write-back FSM.
package L1_cache_types;

    typedef logic [127:0] pmem_bus;

    localparam int unsigned LineTagBits = 12;
    typedef logic [LineTagBits-1:0] line_addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
`ifdef DCACHE_WB_FWD_EN
        , StFwd
`endif
    } wb_state_t;

endpackage

// File: rtl/lc3b_types.sv
// Basic LC-3b datapath types shared across the memory hierarchy.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

endpackage

// File: rtl/wb_fifo.sv
// Dirty-line FIFO: storage, wrapping head/tail pointers, occupancy count and parallel tag match.
// Build option DCACHE_WB_FWD_EN also exposes the youngest matching entry's data.
module wb_fifo
    import L1_cache_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  line_addr_t push_addr,
    input  pmem_bus    push_data,
    input  logic       pop,
    input  line_addr_t match_addr,
    output logic       match,
`ifdef DCACHE_WB_FWD_EN
    output pmem_bus    match_data,
`endif
    output line_addr_t head_addr,
    output pmem_bus    head_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    line_addr_t      addr_q [DEPTH];
    pmem_bus         data_q [DEPTH];
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the last hit, the youngest entry, wins.
    always_comb begin
        match = 1'b0;
`ifdef DCACHE_WB_FWD_EN
        match_data = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CntW'(k) < count_q) && (addr_q[head_q + PtrW'(k)] == match_addr)) begin
                match = 1'b1;
`ifdef DCACHE_WB_FWD_EN
                match_data = data_q[head_q + PtrW'(k)];
`endif
            end
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the L1 dcache and physical memory; fills bypass queued evictions.
// Build option DCACHE_WB_FWD_EN serves fills that hit a buffered line directly from the buffer.
module dcache_wb_buffer
    import L1_cache_types::*;
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     wb_write,
    input  lc3b_word wb_address,
    input  pmem_bus  wb_wdata,
    output logic     wb_resp,
    input  logic     dc_read,
    input  lc3b_word dc_address,
    output pmem_bus  dc_rdata,
    output logic     dc_resp,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address,
    output pmem_bus  pmem_wdata,
    input  pmem_bus  pmem_rdata,
    input  logic     pmem_resp,
    output logic     wb_full,
    output logic     wb_empty
);

    wb_state_t  state_q;
    logic       push;
    logic       pop;
    logic       match;
    logic       full;
    logic       empty;
    line_addr_t head_addr;
    pmem_bus    head_data;
`ifdef DCACHE_WB_FWD_EN
    pmem_bus    match_data;
`endif

    // Line offset bits carry no information for whole-line traffic.
    logic unused_offsets;
    assign unused_offsets = ^{wb_address[3:0], dc_address[3:0]};

    assign push = wb_write && !full && reset_n;
    assign pop  = (state_q == StWrite) && pmem_resp;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_addr (wb_address[15:4]),
        .push_data (wb_wdata),
        .pop       (pop),
        .match_addr(dc_address[15:4]),
        .match     (match),
`ifdef DCACHE_WB_FWD_EN
        .match_data(match_data),
`endif
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    // Without forwarding a matching fill falls through to WRITE and drains until the hit is gone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dc_read && !match) begin
                        state_q <= StRead;
`ifdef DCACHE_WB_FWD_EN
                    end else if (dc_read && match) begin
                        state_q <= StFwd;
`endif
                    end else if (!empty) begin
                        state_q <= StWrite;
                    end
                end
                StRead: begin
                    if (pmem_resp) state_q <= StIdle;
                end
                StWrite: begin
                    if (pmem_resp) state_q <= StIdle;
                end
`ifdef DCACHE_WB_FWD_EN
                StFwd: begin
                    state_q <= StIdle;
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        dc_resp      = 1'b0;
        dc_rdata     = '0;
        unique case (state_q)
            StRead: begin
                pmem_read    = 1'b1;
                pmem_address = {dc_address[15:4], 4'b0000};
                if (pmem_resp) begin
                    dc_resp  = 1'b1;
                    dc_rdata = pmem_rdata;
                end
            end
            StWrite: begin
                pmem_write   = 1'b1;
                pmem_address = {head_addr, 4'b0000};
                pmem_wdata   = head_data;
            end
`ifdef DCACHE_WB_FWD_EN
            StFwd: begin
                dc_resp  = 1'b1;
                dc_rdata = match_data;
            end
`endif
            default: begin
            end
        endcase
    end

    assign wb_resp  = push;
    assign wb_full  = full;
    assign wb_empty = empty;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed scenarios plus a randomized run
// checked against a queue model of the buffer contents.
module tb_dcache_wb_buffer;

    localparam int unsigned DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wb_write;
    logic [15:0]  wb_address;
    logic [127:0] wb_wdata;
    logic         wb_resp;
    logic         dc_read;
    logic [15:0]  dc_address;
    logic [127:0] dc_rdata;
    logic         dc_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         wb_full;
    logic         wb_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_wb_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_write    (wb_write),
        .wb_address  (wb_address),
        .wb_wdata    (wb_wdata),
        .wb_resp     (wb_resp),
        .dc_read     (dc_read),
        .dc_address  (dc_address),
        .dc_rdata    (dc_rdata),
        .dc_resp     (dc_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .wb_full     (wb_full),
        .wb_empty    (wb_empty)
    );

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        wb_write   = 1'b0;
        wb_address = '0;
        wb_wdata   = '0;
        dc_read    = 1'b0;
        dc_address = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    // Returns at a falling edge with reset released; the DUT is idle and empty.
    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Queues two lines behind a stalled fill of 0x9000 so both sit in the buffer while IDLE.
    task automatic fill_behind_read(input logic [15:0] a0, input logic [127:0] d0,
                                    input logic [15:0] a1, input logic [127:0] d1);
        dc_read    = 1'b1;
        dc_address = 16'h9000;
        wb_write   = 1'b1;
        wb_address = a0;
        wb_wdata   = d0;
        @(negedge clk);
        wb_address = a1;
        wb_wdata   = d1;
        @(negedge clk);
        wb_write   = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = rand128();
        @(negedge clk);
        pmem_resp  = 1'b0;
        dc_read    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        wb_write   = 1'b1;
        wb_address = 16'h1230;
        dc_read    = 1'b1;
        dc_address = 16'h5000;
        pmem_resp  = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (wb_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_empty: got %b want 1", wb_empty);
        end
        checks++;
        if ({wb_full, wb_resp, dc_resp, pmem_read, pmem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {wb_full, wb_resp, dc_resp, pmem_read, pmem_write});
        end
        checks++;
        if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0 || dc_rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got addr %h wdata %h rdata %h want all 0",
                     pmem_address, pmem_wdata, dc_rdata);
        end
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (wb_empty !== 1'b1 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got empty %b write %b want 1 0", wb_empty, pmem_write);
        end
    endtask

    task automatic test_push_write();
        logic [127:0] d1;
        apply_reset();
        d1         = rand128();
        wb_write   = 1'b1;
        wb_address = 16'h123F;
        wb_wdata   = d1;
        #1;
        checks++;
        if (wb_resp !== 1'b1) begin
            errors++;
            $display("FAIL push_resp: got %b want 1", wb_resp);
        end
        @(negedge clk);
        wb_write = 1'b0;
        #1;
        checks++;
        if (wb_empty !== 1'b0) begin
            errors++;
            $display("FAIL push_not_empty: got %b want 0", wb_empty);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h1230
            || pmem_wdata !== d1) begin
            errors++;
            $display("FAIL push_write_cmd: got w %b r %b addr %h data %h want 1 0 1230 %h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, d1);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (wb_empty !== 1'b1 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL push_drained: got empty %b write %b want 1 0", wb_empty, pmem_write);
        end
    endtask

    task automatic test_full();
        logic [127:0] db;
        logic [127:0] dc;
        apply_reset();
        db         = rand128();
        dc         = rand128();
        wb_write   = 1'b1;
        wb_address = 16'h1000;
        wb_wdata   = rand128();
        @(negedge clk);
        wb_address = 16'h2000;
        wb_wdata   = db;
        #1;
        checks++;
        if (wb_resp !== 1'b1) begin
            errors++;
            $display("FAIL full_second_push: got %b want 1", wb_resp);
        end
        @(negedge clk);
        wb_address = 16'h3000;
        wb_wdata   = dc;
        #1;
        checks++;
        if (wb_full !== 1'b1 || wb_resp !== 1'b0) begin
            errors++;
            $display("FAIL full_third_refused: got full %b resp %b want 1 0", wb_full, wb_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (wb_resp !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_deferred: got %b want 0", wb_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (wb_resp !== 1'b1 || wb_full !== 1'b0) begin
            errors++;
            $display("FAIL full_third_accepted: got resp %b full %b want 1 0", wb_resp, wb_full);
        end
        @(negedge clk);
        wb_write = 1'b0;
        #1;
        checks++;
        if (wb_full !== 1'b1 || pmem_write !== 1'b1 || pmem_address !== 16'h2000
            || pmem_wdata !== db) begin
            errors++;
            $display("FAIL full_second_write: got full %b w %b addr %h data %h want 1 1 2000 %h",
                     wb_full, pmem_write, pmem_address, pmem_wdata, db);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h3000 || pmem_wdata !== dc) begin
            errors++;
            $display("FAIL full_third_write: got w %b addr %h data %h want 1 3000 %h",
                     pmem_write, pmem_address, pmem_wdata, dc);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (wb_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drained: got %b want 1", wb_empty);
        end
    endtask

    task automatic test_read_priority();
        logic [127:0] d4;
        logic [127:0] r5;
        apply_reset();
        d4         = rand128();
        r5         = rand128();
        wb_write   = 1'b1;
        wb_address = 16'h4000;
        wb_wdata   = d4;
        @(negedge clk);
        wb_write   = 1'b0;
        dc_read    = 1'b1;
        dc_address = 16'h5008;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h5000) begin
            errors++;
            $display("FAIL rdprio_read_first: got r %b w %b addr %h want 1 0 5000",
                     pmem_read, pmem_write, pmem_address);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = r5;
        #1;
        checks++;
        if (dc_resp !== 1'b1 || dc_rdata !== r5) begin
            errors++;
            $display("FAIL rdprio_fill_data: got resp %b data %h want 1 %h", dc_resp, dc_rdata, r5);
        end
        @(negedge clk);
        dc_read   = 1'b0;
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (dc_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL rdprio_idle: got resp %b r %b want 0 0", dc_resp, pmem_read);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h4000 || pmem_wdata !== d4) begin
            errors++;
            $display("FAIL rdprio_write_after: got w %b addr %h data %h want 1 4000 %h",
                     pmem_write, pmem_address, pmem_wdata, d4);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    task automatic test_match();
        logic [127:0] d0;
        logic [127:0] d6;
        logic [127:0] r6;
        apply_reset();
        d0 = rand128();
        d6 = rand128();
        r6 = rand128();
        fill_behind_read(16'h1000, d0, 16'h6000, d6);
        dc_read    = 1'b1;
        dc_address = 16'h6004;
        #1;
        checks++;
        if (wb_full !== 1'b1) begin
            errors++;
            $display("FAIL match_setup_full: got %b want 1", wb_full);
        end
        @(negedge clk);
        #1;
`ifdef DCACHE_WB_FWD_EN
        checks++;
        if (dc_resp !== 1'b1 || dc_rdata !== d6 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL match_fwd: got resp %b data %h r %b w %b want 1 %h 0 0",
                     dc_resp, dc_rdata, pmem_read, pmem_write, d6);
        end
        dc_read = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (wb_full !== 1'b1 || dc_resp !== 1'b0) begin
            errors++;
            $display("FAIL match_fwd_retained: got full %b resp %b want 1 0", wb_full, dc_resp);
        end
`else
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h1000
            || pmem_wdata !== d0) begin
            errors++;
            $display("FAIL match_drain_first: got w %b r %b addr %h data %h want 1 0 1000 %h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, d0);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h6000
            || pmem_wdata !== d6) begin
            errors++;
            $display("FAIL match_drain_second: got w %b r %b addr %h data %h want 1 0 6000 %h",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, d6);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h6000) begin
            errors++;
            $display("FAIL match_read_after_drain: got r %b w %b addr %h want 1 0 6000",
                     pmem_read, pmem_write, pmem_address);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = r6;
        #1;
        checks++;
        if (dc_resp !== 1'b1 || dc_rdata !== r6) begin
            errors++;
            $display("FAIL match_fill_data: got resp %b data %h want 1 %h", dc_resp, dc_rdata, r6);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        dc_read   = 1'b0;
`endif
    endtask

    task automatic test_youngest();
        logic [127:0] da;
        logic [127:0] db;
        apply_reset();
        da = rand128();
        db = rand128();
        fill_behind_read(16'h7000, da, 16'h7000, db);
        dc_read    = 1'b1;
        dc_address = 16'h7000;
        @(negedge clk);
        #1;
`ifdef DCACHE_WB_FWD_EN
        checks++;
        if (dc_resp !== 1'b1 || dc_rdata !== db) begin
            errors++;
            $display("FAIL youngest_fwd: got resp %b data %h want 1 %h", dc_resp, dc_rdata, db);
        end
        dc_read = 1'b0;
`else
        checks++;
        if (pmem_write !== 1'b1 || pmem_wdata !== da) begin
            errors++;
            $display("FAIL youngest_order_a: got w %b data %h want 1 %h", pmem_write, pmem_wdata, da);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_wdata !== db) begin
            errors++;
            $display("FAIL youngest_order_b: got w %b data %h want 1 %h", pmem_write, pmem_wdata, db);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h7000) begin
            errors++;
            $display("FAIL youngest_read: got r %b addr %h want 1 7000", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        dc_read   = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        wb_write   = 1'b1;
        wb_address = 16'h8000;
        wb_wdata   = rand128();
        @(negedge clk);
        wb_write = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_write: got %b want 1", pmem_write);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || wb_empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_dropped: got w %b empty %b want 0 1", pmem_write, wb_empty);
        end
        pmem_resp = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (wb_empty !== 1'b1 || wb_full !== 1'b0 || dc_resp !== 1'b0
                || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stray_resp: got empty %b full %b resp %b r %b w %b want 1 0 0 0 0",
                         wb_empty, wb_full, dc_resp, pmem_read, pmem_write);
            end
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0]  q_line[$];
        logic [127:0] q_data[$];
        logic [11:0]  pool[4];
        logic         drop_wr;
        logic         drop_rd;
        int           rd_age;
        bit           hung;
        pool    = '{12'h100, 12'h200, 12'h300, 12'h400};
        drop_wr = 1'b0;
        drop_rd = 1'b0;
        rd_age  = 0;
        hung    = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 3000 && !hung; cyc++) begin
            logic [11:0]  l;
            logic         acc;
            logic         hit;
            logic [127:0] young;
            if (drop_wr) wb_write = 1'b0;
            if (drop_rd) dc_read = 1'b0;
            if (!dc_read && $urandom_range(3) == 0) begin
                l = pool[$urandom_range(3)];
                if (!(wb_write && l == wb_address[15:4])) begin
                    dc_read    = 1'b1;
                    dc_address = {l, 4'($urandom_range(15))};
                    rd_age     = 0;
                end
            end
            if (!wb_write && $urandom_range(1) == 0) begin
                l = pool[$urandom_range(3)];
                if (!(dc_read && l == dc_address[15:4])) begin
                    wb_write   = 1'b1;
                    wb_address = {l, 4'($urandom_range(15))};
                    wb_wdata   = rand128();
                end
            end
            if (pmem_read || pmem_write) pmem_resp = ($urandom_range(2) == 0);
            else pmem_resp = ($urandom_range(7) == 0);
            pmem_rdata = rand128();
            #1;
            hit   = 1'b0;
            young = '0;
            for (int i = 0; i < q_line.size(); i++) begin
                if (q_line[i] == dc_address[15:4]) begin
                    hit   = 1'b1;
                    young = q_data[i];
                end
            end
            acc = wb_write && (q_line.size() < DEPTH);
            checks++;
            if (wb_empty !== (q_line.size() == 0) || wb_full !== (q_line.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand_status: got empty %b full %b want occupancy %0d",
                         wb_empty, wb_full, q_line.size());
            end
            checks++;
            if (wb_resp !== acc) begin
                errors++;
                $display("FAIL rand_wb_resp: got %b want %b", wb_resp, acc);
            end
            checks++;
            if (pmem_read && pmem_write) begin
                errors++;
                $display("FAIL rand_exclusive: got r %b w %b want not both", pmem_read, pmem_write);
            end
            if (pmem_write) begin
                checks++;
                if (q_line.size() == 0) begin
                    errors++;
                    $display("FAIL rand_write_empty: got write with %0d entries want none", 0);
                end else if (pmem_address !== {q_line[0], 4'h0} || pmem_wdata !== q_data[0]) begin
                    errors++;
                    $display("FAIL rand_write_head: got addr %h data %h want %h %h",
                             pmem_address, pmem_wdata, {q_line[0], 4'h0}, q_data[0]);
                end
            end
            if (pmem_read) begin
                checks++;
                if (!dc_read || hit || pmem_address !== {dc_address[15:4], 4'h0}) begin
                    errors++;
                    $display("FAIL rand_read_cmd: got addr %h req %b hit %b want %h 1 0",
                             pmem_address, dc_read, hit, {dc_address[15:4], 4'h0});
                end
            end
            checks++;
            if (pmem_read && pmem_resp) begin
                if (dc_resp !== 1'b1 || dc_rdata !== pmem_rdata) begin
                    errors++;
                    $display("FAIL rand_fill: got resp %b data %h want 1 %h",
                             dc_resp, dc_rdata, pmem_rdata);
                end
            end else if (dc_resp) begin
`ifdef DCACHE_WB_FWD_EN
                if (!dc_read || !hit || dc_rdata !== young) begin
                    errors++;
                    $display("FAIL rand_fwd: got data %h req %b hit %b want %h 1 1",
                             dc_rdata, dc_read, hit, young);
                end
`else
                errors++;
                $display("FAIL rand_spurious_resp: got dc_resp %b want 0 (young %h)", dc_resp, young);
`endif
            end
            if (pmem_write && pmem_resp && q_line.size() > 0) begin
                void'(q_line.pop_front());
                void'(q_data.pop_front());
            end
            if (acc) begin
                q_line.push_back(wb_address[15:4]);
                q_data.push_back(wb_wdata);
            end
            drop_wr = acc;
            drop_rd = dc_resp;
            if (dc_read && !dc_resp) begin
                rd_age++;
                if (rd_age > 300) begin
                    errors++;
                    $display("FAIL rand_fill_timeout: got no dc_resp after %0d cycles want <= 300",
                             rd_age);
                    hung = 1'b1;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_push_write();
        test_full();
        test_read_priority();
        test_match();
        test_youngest();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
